shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Sub-controller that sequences the register shifter and its shift-amount mux for shift-class instructions: SLL, SRL, SRA, SLLV, SRAV and LUI-by-16.
- The main control FSM hands off with a start/done handshake.
- This block drives the shifter operation code, the amount-mux select, the value-source select and the register-file write strobe.
- The main FSM regains the datapath when done is asserted.

Parameters:
- SHIFT_WAIT, 1, cycles the shift opcode is held in S_SHIFT (legal range 1..15); covers slower shifter builds.
- CNT_W, 4, width of the S_SHIFT hold counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the main FSM; sampled only in S_IDLE.
- op  in  3  shift class: 000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRAV, 101 LUI16, 110/111 illegal.
- shamt_field  in  5  instruction shamt bits [10:6].
- amt_reg  in  5  low 5 bits of register B.
- busy  out  1  high from the cycle after start is accepted until the end of S_WB.
- done  out  1  one-cycle pulse during S_WB.
- illegal  out  1  one-cycle pulse when start arrives with op 110/111.
- shift_ctrl  out  3  shifter command: 000 nop, 001 load, 010 left, 011 right logical, 100 right arithmetic.
- shamt_sel  out  2  amount mux select: 00 shamt_field, 01 constant 16, 10 register B.
- src_sel  out  1  shifter load source: 0 register B, 1 immediate.
- regwrite  out  1  register-file write strobe; high only in S_WB.

Behaviour:
- States: S_IDLE, S_LOAD, S_SHIFT, S_WB.
- All outputs are Moore outputs, decoded from the state register and op_q (op latched on accept).
- Reset: asynchronous on reset_n low.
  - State goes to S_IDLE, counter to 0, op_q to 000.
  - busy, done, illegal, regwrite = 0; shift_ctrl = 000; shamt_sel = 00; src_sel = 0.
  - Reset asserted mid-operation aborts with no regwrite; the next start after release is serviced normally.
- S_IDLE:
  - start=1 with a legal op: latch op_q, go to S_LOAD.
  - start=1 with op 110/111: illegal=1 on the next cycle for exactly one cycle, stay in S_IDLE, busy stays 0.
  - start=0: hold.
- S_LOAD (1 cycle):
  - shift_ctrl=001.
  - src_sel=1 for LUI16, otherwise 0.
  - shamt_sel per op: SLL/SRL/SRA = 00; SLLV/SRAV = 10; LUI16 = 01.
  - Load counter with SHIFT_WAIT-1. Go to S_SHIFT.
- S_SHIFT:
  - shift_ctrl: SLL/SLLV/LUI16 = 010; SRL = 011; SRA/SRAV = 100.
  - shamt_sel is held from S_LOAD.
  - Decrement the counter each cycle; go to S_WB when the counter reads 0.
  - Dwell is exactly SHIFT_WAIT cycles.
- S_WB (1 cycle): shift_ctrl=000, regwrite=1, done=1. Go to S_IDLE.
- Latency: start accepted at cycle N → done/regwrite at cycle N+2+SHIFT_WAIT. Default: N+3.
- busy=1 in S_LOAD, S_SHIFT and S_WB.
- start while busy is ignored; no queueing.
- A start pulse in the same cycle done is high is ignored.
- op changes after accept have no effect, because op_q is used.
- Amount 0 is legal and still passes through S_SHIFT in the base build.
- The shifter masks amounts to 5 bits; this block does no amount arithmetic.

Optional Feature:
- Macro: SHIFT_ZERO_BYPASS_EN.
- Defined:
  - In S_LOAD, if the effective amount is 0, go directly to S_WB, skipping S_SHIFT.
  - Effective amount is shamt_field for SLL/SRL/SRA and amt_reg for SLLV/SRAV, sampled in S_LOAD.
  - LUI16 is never bypassed.
  - Bypass latency is N+2.
- Undefined: amount inputs are ignored for sequencing; S_SHIFT is always visited.

Test Plan:
- Reset: hold reset_n=0 mid-S_SHIFT → all outputs 0 immediately, state S_IDLE, no regwrite pulse after release.
- SLL, shamt_field=5, SHIFT_WAIT=1:
  - shift_ctrl 001, then 010, then 000 over three cycles.
  - shamt_sel=00 throughout; regwrite/done at N+3; busy high for 3 cycles.
- SRAV, amt_reg=31, SHIFT_WAIT=3: shamt_sel=10, shift_ctrl=100 for exactly 3 cycles, done at N+5.
- LUI16: src_sel=1 and shamt_sel=01 in S_LOAD; shift_ctrl=010; regwrite at N+3.
- op=111 with start: illegal pulses one cycle, busy stays 0, regwrite stays 0.
- start re-asserted with op=SRL during busy → ignored; exactly one done pulse.
- Under SHIFT_ZERO_BYPASS_EN: SLL with shamt_field=0 → no 010 command, done at N+2; LUI16 still takes N+3.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences the register shifter for SLL/SRL/SRA/SLLV/SRAV/LUI16.
// The main FSM hands over with start and takes the datapath back on done.
// Build option: define SHIFT_ZERO_BYPASS_EN to let a zero shift amount skip
// S_SHIFT (LUI16 excepted). Without it, S_SHIFT is always visited.
// Outputs are Moore decodes of (state, op_q), registered from the next-state
// values so they change cleanly on the clock edge.
module shift_seq_ctrl #(
  parameter int SHIFT_WAIT = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] shamt_field,
  input  logic [4:0] amt_reg,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [2:0] shift_ctrl,
  output logic [1:0] shamt_sel,
  output logic       src_sel,
  output logic       regwrite
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLV = 3'b011;
  localparam logic [2:0] OP_SRAV = 3'b100;
  localparam logic [2:0] OP_LUI  = 3'b101;

  localparam logic [2:0] SC_NOP   = 3'b000;
  localparam logic [2:0] SC_LOAD  = 3'b001;
  localparam logic [2:0] SC_LEFT  = 3'b010;
  localparam logic [2:0] SC_RLOG  = 3'b011;
  localparam logic [2:0] SC_RARI  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SHIFT_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_d;

  logic             busy_q, done_q, illegal_q, src_sel_q, regwrite_q;
  logic [2:0]       shift_ctrl_q;
  logic [1:0]       shamt_sel_q;

  // Amount-mux select: variable shifts take register B, LUI takes constant 16.
  function automatic logic [1:0] amt_sel(input logic [2:0] o);
    logic [1:0] s;
    case (o)
      OP_SLLV, OP_SRAV: s = 2'b10;
      OP_LUI:           s = 2'b01;
      default:          s = 2'b00;
    endcase
    return s;
  endfunction

  // Shift direction command used while in S_SHIFT.
  function automatic logic [2:0] shift_dir(input logic [2:0] o);
    logic [2:0] d;
    case (o)
      OP_SRL:          d = SC_RLOG;
      OP_SRA, OP_SRAV: d = SC_RARI;
      default:         d = SC_LEFT;
    endcase
    return d;
  endfunction

  // Output decode: {busy, done, shift_ctrl, shamt_sel, src_sel, regwrite}.
  function automatic logic [8:0] decode(input logic [1:0] st, input logic [2:0] o);
    logic       bsy;
    logic       dn;
    logic [2:0] sc;
    logic [1:0] ss;
    logic       src;
    bsy = 1'b0;
    dn  = 1'b0;
    sc  = SC_NOP;
    ss  = 2'b00;
    src = 1'b0;
    case (st)
      S_LOAD: begin
        bsy = 1'b1;
        sc  = SC_LOAD;
        ss  = amt_sel(o);
        src = (o == OP_LUI);
      end
      S_SHIFT: begin
        bsy = 1'b1;
        sc  = shift_dir(o);
        ss  = amt_sel(o);
      end
      S_WB: begin
        bsy = 1'b1;
        dn  = 1'b1;
      end
      default: begin
        bsy = 1'b0;
      end
    endcase
    return {bsy, dn, sc, ss, src, dn};
  endfunction

`ifdef SHIFT_ZERO_BYPASS_EN
  // Effective amount is zero: immediate field for fixed shifts, register B
  // for variable shifts; LUI16 always shifts by 16 so never qualifies.
  function automatic logic amt_is_zero(input logic [2:0] o, input logic [4:0] sh,
                                       input logic [4:0] ar);
    logic z;
    case (o)
      OP_SLL, OP_SRL, OP_SRA: z = (sh == 5'd0);
      OP_SLLV, OP_SRAV:       z = (ar == 5'd0);
      default:                z = 1'b0;
    endcase
    return z;
  endfunction
`else
  // Amount inputs only feed the shifter datapath in this build.
  logic amt_unused_s;
  assign amt_unused_s = ^{shamt_field, amt_reg};
`endif

  // Next-state, op latch and dwell counter logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op <= OP_LUI) begin
            op_d    = op;
            state_d = S_LOAD;
          end else begin
            illegal_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d = CNT_LOAD;
`ifdef SHIFT_ZERO_BYPASS_EN
        if (amt_is_zero(op_q, shamt_field, amt_reg)) begin
          state_d = S_WB;
        end else begin
          state_d = S_SHIFT;
        end
`else
        state_d = S_SHIFT;
`endif
      end
      S_SHIFT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched op and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {busy_q, done_q, shift_ctrl_q, shamt_sel_q, src_sel_q, regwrite_q} <= 9'd0;
      illegal_q <= 1'b0;
    end else begin
      {busy_q, done_q, shift_ctrl_q, shamt_sel_q, src_sel_q, regwrite_q} <= decode(state_d, op_d);
      illegal_q <= illegal_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign shift_ctrl = shift_ctrl_q;
  assign shamt_sel  = shamt_sel_q;
  assign src_sel    = src_sel_q;
  assign regwrite   = regwrite_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (SHIFT_WAIT=1 and 3) share stimulus.
// A timeline model predicts every output from cycles-since-accept; directed
// runs additionally pin latencies and command counts to hand-computed values.
module tb_shift_seq_ctrl;

`ifdef SHIFT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [4:0] shamt;
  logic [4:0] amt;

  logic [1:0] busy_w, done_w, ill_w, src_w, rw_w;
  logic [2:0] sc_w [2];
  logic [1:0] ss_w [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ld_val = 0;

  // model state: rel = cycles into the operation (1 = load cycle), -1 idle
  int         rel [2] = '{-1, -1};
  int         wbr [2] = '{0, 0};
  logic [2:0] mop [2] = '{3'b000, 3'b000};
  logic       ill [2] = '{1'b0, 1'b0};

  shift_seq_ctrl #(.SHIFT_WAIT(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .shamt_field(shamt), .amt_reg(amt),
    .busy(busy_w[0]), .done(done_w[0]), .illegal(ill_w[0]),
    .shift_ctrl(sc_w[0]), .shamt_sel(ss_w[0]), .src_sel(src_w[0]), .regwrite(rw_w[0])
  );

  shift_seq_ctrl #(.SHIFT_WAIT(3), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .shamt_field(shamt), .amt_reg(amt),
    .busy(busy_w[1]), .done(done_w[1]), .illegal(ill_w[1]),
    .shift_ctrl(sc_w[1]), .shamt_sel(ss_w[1]), .src_sel(src_w[1]), .regwrite(rw_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic zero_amount(input logic [2:0] o);
    if (o == 3'b011 || o == 3'b100) return (amt == 5'd0);
    if (o == 3'b101) return 1'b0;
    return (shamt == 5'd0);
  endfunction

  // Timeline model: an accepted op lasts load + wait shift cycles + writeback.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        rel[i] <= -1;
        wbr[i] <= 0;
        mop[i] <= 3'b000;
        ill[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        ill[i] <= 1'b0;
        if (rel[i] < 0) begin
          if (start) begin
            if (op > 3'b101) ill[i] <= 1'b1;
            else begin
              rel[i] <= 1;
              mop[i] <= op;
              wbr[i] <= wait_of(i) + 2;
            end
          end
        end else if (rel[i] == 1 && BYP && zero_amount(mop[i])) begin
          rel[i] <= 2;
          wbr[i] <= 2;
        end else if (rel[i] >= wbr[i]) begin
          rel[i] <= -1;
        end else begin
          rel[i] <= rel[i] + 1;
        end
      end
    end
  end

  function automatic logic [1:0] sel_of(input logic [2:0] o);
    if (o == 3'b011 || o == 3'b100) return 2'b10;
    if (o == 3'b101) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [2:0] dir_of(input logic [2:0] o);
    if (o == 3'b001) return 3'b011;
    if (o == 3'b010 || o == 3'b100) return 3'b100;
    return 3'b010;
  endfunction

  // {busy, done, illegal, shift_ctrl, shamt_sel, src_sel, regwrite}
  function automatic logic [9:0] exp_vec(input int i);
    if (rel[i] < 0) return {2'b00, ill[i], 7'b0000000};
    if (rel[i] == 1) return {3'b100, 3'b001, sel_of(mop[i]), (mop[i] == 3'b101), 1'b0};
    if (rel[i] == wbr[i]) return {3'b110, 3'b000, 2'b00, 1'b0, 1'b1};
    return {3'b100, dir_of(mop[i]), sel_of(mop[i]), 1'b0, 1'b0};
  endfunction

  function automatic logic [9:0] got_vec(input int i);
    return {busy_w[i], done_w[i], ill_w[i], sc_w[i], ss_w[i], src_w[i], rw_w[i]};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_vec(i) !== exp_vec(i)) begin
        n_errors++;
        $display("FAIL model_dut%0d: got %b expected %b (cycle %0d)", i, got_vec(i), exp_vec(i), cyc);
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One operation; k>0 re-asserts start with SRL k cycles after the load cycle.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [4:0] sh,
                        input logic [4:0] ar, input int k, input logic [2:0] sc_code,
                        input int e_lat0, input int e_lat1, input int e_sc0, input int e_sc1,
                        input int e_done, input int e_ill);
    int lat[2];
    int nd[2];
    int nsc[2];
    int nb[2];
    int nil;
    lat = '{-1, -1};
    nd  = '{0, 0};
    nsc = '{0, 0};
    nb  = '{0, 0};
    nil = 0;
    op = o; shamt = sh; amt = ar; start = 1'b1;
    half();
    adv();
    for (int c = 0; c < 12; c++) begin
      if (k > 0 && c == k) begin
        start = 1'b1;
        op = 3'b001;
      end else begin
        start = 1'b0;
      end
      half();
      for (int i = 0; i < 2; i++) begin
        if (done_w[i]) begin
          nd[i]++;
          if (lat[i] < 0) lat[i] = c + 1;
        end
        if (sc_w[i] == sc_code) nsc[i]++;
        if (busy_w[i]) nb[i]++;
        if (ill_w[i]) nil++;
      end
      if (c == 0) ld_val = int'({src_w[0], ss_w[0]});
      adv();
    end
    start = 1'b0;
    chk({nm, "_lat0"}, lat[0], e_lat0);
    chk({nm, "_lat1"}, lat[1], e_lat1);
    chk({nm, "_cmd0"}, nsc[0], e_sc0);
    chk({nm, "_cmd1"}, nsc[1], e_sc1);
    chk({nm, "_done0"}, nd[0], e_done);
    chk({nm, "_done1"}, nd[1], e_done);
    chk({nm, "_busy0"}, nb[0], (e_lat0 > 0) ? e_lat0 : 0);
    chk({nm, "_busy1"}, nb[1], (e_lat1 > 0) ? e_lat1 : 0);
    chk({nm, "_illegal"}, nil, e_ill);
  endtask

  initial begin
    int nrw;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; shamt = 5'd0; amt = 5'd0;
    adv();
    repeat (2) begin half(); adv(); end
    chk("reset_out0", int'(got_vec(0)), 0);
    chk("reset_out1", int'(got_vec(1)), 0);
    reset_n = 1'b1;
    half();
    adv();

    // SLL by 5
    run_op("sll5", 3'b000, 5'd5, 5'd0, 0, 3'b010, 3, 5, 1, 3, 1, 0);
    // SRAV by register 31
    run_op("srav31", 3'b100, 5'd0, 5'd31, 0, 3'b100, 3, 5, 1, 3, 1, 0);
    // LUI16 with zero shamt field: never bypassed
    run_op("lui", 3'b101, 5'd0, 5'd0, 0, 3'b010, 3, 5, 1, 3, 1, 0);
    chk("lui_load_sel", ld_val, 5);
    // illegal op
    run_op("ill7", 3'b111, 5'd3, 5'd3, 0, 3'b001, -1, -1, 0, 0, 0, 2);
    // SLLV with SRL start re-asserted mid-operation: no SRL command ever
    run_op("busy_restart", 3'b011, 5'd0, 5'd9, 1, 3'b011, 3, 5, 0, 0, 1, 0);
    // SRA with start re-asserted while dut0 is in writeback
    run_op("wb_restart", 3'b010, 5'd4, 5'd0, 2, 3'b100, 3, 5, 1, 3, 1, 0);
    // zero amounts
    run_op("sll0", 3'b000, 5'd0, 5'd6, 0, 3'b010, BYP ? 2 : 3, BYP ? 2 : 5,
           BYP ? 0 : 1, BYP ? 0 : 3, 1, 0);
    run_op("sllv0", 3'b011, 5'd7, 5'd0, 0, 3'b010, BYP ? 2 : 3, BYP ? 2 : 5,
           BYP ? 0 : 1, BYP ? 0 : 3, 1, 0);

    // reset in the middle of S_SHIFT
    op = 3'b100; amt = 5'd31; shamt = 5'd0; start = 1'b1;
    half(); adv();
    start = 1'b0;
    half(); adv();
    reset_n = 1'b0;
    #1;
    chk("midreset_out0", int'(got_vec(0)), 0);
    chk("midreset_out1", int'(got_vec(1)), 0);
    half(); adv();
    half(); adv();
    reset_n = 1'b1;
    nrw = 0;
    for (int c = 0; c < 8; c++) begin
      half();
      if (rw_w != 2'b00) nrw++;
      adv();
    end
    chk("midreset_no_wb", nrw, 0);

    // serviced normally after reset
    run_op("srl_after_reset", 3'b001, 5'd2, 5'd0, 0, 3'b011, 3, 5, 1, 3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
